// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART front end. It sits between the CPU data
// port and the async_receiver/async_transmitter pair.
//   DATA   (addr_i[2]=0): a read pops an RX byte, a write pushes a TX byte.
//   STATUS (addr_i[2]=1): {irq_en, 0, overrun, rx_not_empty, tx_not_full}.
// Optional feature macro UART_IRQ_EN adds an irq-enable register (STATUS bit4)
// and a registered interrupt output. Without the macro uart_int_o is tied to 0.
//
// TX drain FSM:
//   state     | meaning
//   S_IDLE    | waiting for a queued byte and an idle transmitter
//   S_START   | tx_start_o high for this single cycle
//   S_WAIT_HI | waiting up to 4 cycles for tx_busy_i to rise
//   S_WAIT_LO | frame in flight, waiting for tx_busy_i to fall
module uart_mmio_ctrl #(
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_ready_i,
   output logic        rx_clear_o,
   input  logic        tx_busy_i,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   output logic        uart_int_o
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_AW + 1;
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} tx_state_t;

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0] rx_count;
   logic             rx_ovr;

   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0] tx_count;

   tx_state_t        tx_state;
   logic [1:0]       hi_timer;
   logic             irq_en;

   logic rd_data, rd_stat, wr_data, wr_stat;
   logic rx_ne, rx_full, tx_ne, tx_full;
   logic rx_cap, rx_push, rx_pop, tx_push, tx_pop;
   logic unused_bits;

   assign rd_data = ce_i & ~we_i & ~addr_i[2];
   assign rd_stat = ce_i & ~we_i &  addr_i[2];
   assign wr_data = ce_i &  we_i & ~addr_i[2] & sel_i[0];
   assign wr_stat = ce_i &  we_i &  addr_i[2] & sel_i[0];

   assign rx_ne   = (rx_count != '0);
   assign rx_full = (rx_count == RX_CW'(RX_DEPTH));
   assign tx_ne   = (tx_count != '0);
   assign tx_full = (tx_count == TX_CW'(TX_DEPTH));

   // A byte is taken only on the first cycle of rx_ready_i; the clear pulse
   // masks the following cycle. A full FIFO still accepts if a pop frees a slot.
   assign rx_cap  = rx_ready_i & ~rx_clear_o;
   assign rx_pop  = rd_data & rx_ne;
   assign rx_push = rx_cap & (~rx_full | rx_pop);
   assign tx_push = wr_data & ~tx_full;
   assign tx_pop  = (tx_state == S_IDLE) & tx_ne & ~tx_busy_i;

   assign unused_bits = ^{addr_i[31:3], addr_i[1:0], sel_i[3:1], data_i[31:8], wr_stat};

   // Combinational read mux; nothing is driven unless this is a read cycle.
   always_comb begin
      data_o = '0;
      if (rd_data && rx_ne)
         data_o[7:0] = rx_mem[rx_rd_ptr];
      else if (rd_stat)
         data_o = {27'b0, irq_en, 1'b0, rx_ovr, rx_ne, ~tx_full};
   end

   // RX FIFO storage (no reset needed, guarded by count).
   always_ff @(posedge clk) begin
      if (rx_push)
         rx_mem[rx_wr_ptr] <= rx_data_i;
   end

   // RX pointers, count, sticky overrun and the receiver clear pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr  <= '0;
         rx_rd_ptr  <= '0;
         rx_count   <= '0;
         rx_ovr     <= 1'b0;
         rx_clear_o <= 1'b0;
      end else begin
         rx_clear_o <= rx_cap;
         if (rx_push)
            rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
         if (rx_pop)
            rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         if (rx_push && !rx_pop)
            rx_count <= rx_count + RX_CW'(1);
         else if (!rx_push && rx_pop)
            rx_count <= rx_count - RX_CW'(1);
         if (rx_cap && !rx_push)
            rx_ovr <= 1'b1;
         else if (rd_stat)
            rx_ovr <= 1'b0;
      end
   end

   // TX FIFO storage.
   always_ff @(posedge clk) begin
      if (tx_push)
         tx_mem[tx_wr_ptr] <= data_i[7:0];
   end

   // TX pointers and count; CPU push and FSM pop may coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push)
            tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
         if (tx_pop)
            tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         if (tx_push && !tx_pop)
            tx_count <= tx_count + TX_CW'(1);
         else if (!tx_push && tx_pop)
            tx_count <= tx_count - TX_CW'(1);
      end
   end

   // TX drain FSM: one byte per transmitter frame, with a timeout in case
   // the transmitter never reports busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state   <= S_IDLE;
         tx_start_o <= 1'b0;
         tx_data_o  <= 8'h00;
         hi_timer   <= 2'd0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               if (tx_pop) begin
                  tx_data_o  <= tx_mem[tx_rd_ptr];
                  tx_start_o <= 1'b1;
                  tx_state   <= S_START;
               end
            end
            S_START: begin
               tx_start_o <= 1'b0;
               hi_timer   <= 2'd3;
               tx_state   <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (tx_busy_i)
                  tx_state <= S_WAIT_LO;
               else if (hi_timer == 2'd0)
                  tx_state <= S_IDLE;
               else
                  hi_timer <= hi_timer - 2'd1;
            end
            S_WAIT_LO: begin
               if (!tx_busy_i)
                  tx_state <= S_IDLE;
            end
            default: begin
               tx_start_o <= 1'b0;
               tx_state   <= S_IDLE;
            end
         endcase
      end
   end

`ifdef UART_IRQ_EN
   // Irq enable register and interrupt, one cycle behind RX FIFO occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en     <= 1'b0;
         uart_int_o <= 1'b0;
      end else begin
         if (wr_stat)
            irq_en <= data_i[4];
         uart_int_o <= irq_en & rx_ne;
      end
   end
`else
   assign irq_en     = 1'b0;
   assign uart_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl. Stimulus tasks update a queue-based
// model and push expected reads / clear pulses / transmitted bytes; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_uart_mmio_ctrl;

   localparam int RXD = 8;
   localparam int TXD = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic [7:0]  rx_data_i = '0;
   logic        rx_ready_i = 1'b0;
   logic        rx_clear_o;
   logic        tx_busy_i = 1'b0;
   logic        tx_start_o;
   logic [7:0]  tx_data_o;
   logic        uart_int_o;

   uart_mmio_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
      .clk        (clk),
      .rst        (rst),
      .ce_i       (ce_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .sel_i      (sel_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .rx_data_i  (rx_data_i),
      .rx_ready_i (rx_ready_i),
      .rx_clear_o (rx_clear_o),
      .tx_busy_i  (tx_busy_i),
      .tx_start_o (tx_start_o),
      .tx_data_o  (tx_data_o),
      .uart_int_o (uart_int_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int passed = 0;
   int starts = 0;

   // behavioural model
   logic [7:0]  rxq[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_rd[$];
   int          exp_clr[$];
   logic        ovr_m = 1'b0;
   logic        ie_m = 1'b0;
   int          bmode = 0;   // 0 never busy, 1 busy 10 cycles after each start, 2 held busy

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // transmitter stand-in
   initial begin
      int bcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (bmode == 2) tx_busy_i = 1'b1;
         else if (bcnt > 0) begin tx_busy_i = 1'b1; bcnt--; end
         else tx_busy_i = 1'b0;
         if (bmode == 1 && tx_start_o && bcnt == 0) bcnt = 10;
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ce_i && !we_i) begin
               if (exp_rd.size() == 0) chk("rd_unexpected", data_o, 32'hxxxx_xxxx);
               else chk("rd_data", data_o, exp_rd.pop_front());
            end
            if (rx_clear_o) begin
               if (exp_clr.size() == 0) chk("rx_clear_unexpected", 32'(cyc), 32'hffff_ffff);
               else chk("rx_clear_cycle", 32'(cyc), 32'(exp_clr.pop_front()));
            end
            if (tx_start_o) begin
               starts++;
               chk("tx_start_while_busy", {31'b0, tx_busy_i}, 32'h0);
               if (exp_tx.size() == 0) chk("tx_start_unexpected", {24'b0, tx_data_o}, 32'hffff_ffff);
               else chk("tx_data", {24'b0, tx_data_o}, {24'b0, exp_tx.pop_front()});
            end
         end
      end
   end

   task automatic bus_rd(input logic st);
      logic [31:0] e;
      ce_i = 1'b1; we_i = 1'b0;
      addr_i = $urandom; addr_i[2] = st;
      sel_i = 4'($urandom); data_i = $urandom;
      if (!st) e = (rxq.size() != 0) ? {24'b0, rxq.pop_front()} : 32'h0;
      else begin
         e = {27'b0, ie_m, 1'b0, ovr_m, (rxq.size() != 0), (exp_tx.size() < TXD)};
         ovr_m = 1'b0;
      end
      exp_rd.push_back(e);
      @(posedge clk); #1;
      ce_i = 1'b0;
   endtask

   task automatic bus_wr(input logic st, input logic [3:0] sel, input logic [31:0] d);
      ce_i = 1'b1; we_i = 1'b1;
      addr_i = $urandom; addr_i[2] = st;
      sel_i = sel; data_i = d;
      if (!st && sel[0] && exp_tx.size() < TXD) exp_tx.push_back(d[7:0]);
`ifdef UART_IRQ_EN
      if (st && sel[0]) ie_m = d[4];
`endif
      @(posedge clk); #1;
      ce_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_ready_i = 1'b1; rx_data_i = b;
      exp_clr.push_back(cyc + 1);
      if (rxq.size() < RXD) rxq.push_back(b);
      else ovr_m = 1'b1;
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_tx.size() != 0 && n < 3000) begin @(posedge clk); n++; end
      chk("tx_drain_timeout", 32'(exp_tx.size()), 32'h0);
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      bus_rd(1'b1);
      bus_rd(1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("reset_no_start", 32'(starts), 32'h0);
      chk("reset_irq", {31'b0, uart_int_o}, 32'h0);

      // single RX byte
      rx_push(8'h41);
      bus_rd(1'b1);
      bus_rd(1'b0);
      bus_rd(1'b1);

      // RX overrun
      for (int i = 1; i <= 9; i++) rx_push(8'(i));
      bus_rd(1'b1);
      for (int i = 0; i < 8; i++) bus_rd(1'b0);
      bus_rd(1'b1);

      // two-byte transmit with busy modelling
      bmode = 1;
      bus_wr(1'b0, 4'b0001, 32'h0000_0055);
      bus_wr(1'b0, 4'b1111, 32'h1234_56AA);
      drain();
      chk("two_starts", 32'(starts), 32'd2);

      // TX full while busy held
      bmode = 2;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) bus_wr(1'b0, 4'b0001, 32'($urandom));
      repeat (5) @(posedge clk);
      #1;
      chk("hold_no_start", 32'(starts), 32'd2);
      bus_rd(1'b1);
      bmode = 1;
      drain();
      chk("full_starts", 32'(starts), 32'd10);

      // ignored writes, then transmitter that never reports busy
      bus_wr(1'b0, 4'b1110, 32'h0000_0077);
      bus_wr(1'b1, 4'b1111, 32'hFFFF_FFEF);
      repeat (10) @(posedge clk);
      #1;
      chk("ignored_no_start", 32'(starts), 32'd10);
      bus_rd(1'b1);
      bmode = 0;
      bus_wr(1'b0, 4'b0001, 32'h0000_00C3);
      bus_wr(1'b0, 4'b0001, 32'h0000_003C);
      drain();
      chk("timeout_starts", 32'(starts), 32'd12);

      // randomized traffic
      bmode = 1;
      for (int i = 0; i < 300; i++) begin
         int r = int'($urandom_range(0, 99));
         if (r < 30) bus_rd(1'b0);
         else if (r < 45) bus_rd(1'b1);
         else if (r < 75) begin
            if (exp_tx.size() < 6) bus_wr(1'b0, 4'($urandom) | 4'b0001, $urandom);
            else bus_rd(1'b0);
         end
         else if (r < 85) bus_wr(1'b0, 4'($urandom) & 4'b1110, $urandom);
         else rx_push(8'($urandom));
      end
      drain();
      while (rxq.size() != 0) bus_rd(1'b0);
      bus_rd(1'b1);
      chk("random_irq", {31'b0, uart_int_o}, 32'h0);

`ifdef UART_IRQ_EN
      bus_wr(1'b1, 4'b0001, 32'h0000_0010);
      rx_ready_i = 1'b1; rx_data_i = 8'h33;
      exp_clr.push_back(cyc + 1);
      rxq.push_back(8'h33);
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      @(negedge clk);
      chk("irq_latency", {31'b0, uart_int_o}, 32'h0);
      @(negedge clk);
      chk("irq_set", {31'b0, uart_int_o}, 32'h1);
      @(posedge clk); #1;
      bus_rd(1'b1);
      bus_rd(1'b0);
      @(negedge clk);
      chk("irq_hold", {31'b0, uart_int_o}, 32'h1);
      @(negedge clk);
      chk("irq_clear", {31'b0, uart_int_o}, 32'h0);
      @(posedge clk); #1;
`else
      s0 = 0;
      repeat (30) begin
         @(negedge clk);
         if (uart_int_o) s0++;
      end
      chk("irq_never", 32'(s0), 32'h0);
      @(posedge clk); #1;
`endif

      repeat (5) @(posedge clk);
      #1;
      chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);
      chk("clr_queue_empty", 32'(exp_clr.size()), 32'h0);
      chk("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
